// File: rtl/sync_updown_counter.sv
// Two-button synchronous up/down counter (0..MAX_COUNT) with a registered 7-segment decoder.
// Each button is synchronised, debounced and edge-detected before it can move the count.
module sync_updown_counter #(
    parameter int DB_LIMIT  = 1000000,
    parameter int DB_W      = 20,
    parameter int MAX_COUNT = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] count,
    output logic [0:6] leds,
    output logic       wrap_up,
    output logic       wrap_down
);

    localparam logic [3:0]      MAX_C   = 4'(MAX_COUNT);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_LIMIT - 1);

    // index 0 = up button, index 1 = down button
    logic [1:0]      btn_raw;
    logic [1:0]      s1;
    logic [1:0]      s2;
    logic [1:0]      lvl;
    logic [1:0]      lvl_d;
    logic [1:0]      press;
    logic [DB_W-1:0] dcnt [2];

    assign btn_raw = {btn_down, btn_up};

    for (genvar i = 0; i < 2; i++) begin : g_btn
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1[i]    <= 1'b0;
                s2[i]    <= 1'b0;
                lvl[i]   <= 1'b0;
                lvl_d[i] <= 1'b0;
                dcnt[i]  <= '0;
            end else begin
                s1[i]    <= btn_raw[i];
                s2[i]    <= s1[i];
                lvl_d[i] <= lvl[i];
                // a change must persist DB_LIMIT consecutive cycles before lvl follows
                if (s2[i] == lvl[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DB_LAST) begin
                    lvl[i]  <= s2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + DB_W'(1);
                end
            end
        end

        assign press[i] = lvl[i] & ~lvl_d[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= 4'd0;
            wrap_up   <= 1'b0;
            wrap_down <= 1'b0;
        end else begin
            wrap_up   <= 1'b0;
            wrap_down <= 1'b0;
            // simultaneous presses cancel out
            case (press)
                2'b01: begin
                    if (count == MAX_C) begin
                        count   <= 4'd0;
                        wrap_up <= 1'b1;
                    end else begin
                        count <= count + 4'd1;
                    end
                end
                2'b10: begin
                    if (count == 4'd0) begin
                        count     <= MAX_C;
                        wrap_down <= 1'b1;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds <= 7'b1111110;
        end else begin
            case (count)
                4'h0: leds <= 7'b1111110;
                4'h1: leds <= 7'b0110000;
                4'h2: leds <= 7'b1101101;
                4'h3: leds <= 7'b1111001;
                4'h4: leds <= 7'b0110011;
                4'h5: leds <= 7'b1011011;
                4'h6: leds <= 7'b1011111;
                4'h7: leds <= 7'b1110000;
                4'h8: leds <= 7'b1111111;
                4'h9: leds <= 7'b1111011;
                4'hA: leds <= 7'b1110111;
                4'hB: leds <= 7'b0011111;
                4'hC: leds <= 7'b1001110;
                4'hD: leds <= 7'b0111101;
                4'hE: leds <= 7'b1001111;
                default: leds <= 7'b1000111;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_updown_counter.sv
// Bench for sync_updown_counter: directed button stimulus, expected count events queued
// at drive time and matched by a negedge monitor against count, wrap pulses, timing and leds.
module tb_sync_updown_counter;

    localparam int DB   = 4;
    localparam int MAXC = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic [3:0] count;
    logic [0:6] leds;
    logic       wrap_up;
    logic       wrap_down;

    sync_updown_counter #(.DB_LIMIT(DB), .DB_W(3), .MAX_COUNT(MAXC)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .count     (count),
        .leds      (leds),
        .wrap_up   (wrap_up),
        .wrap_down (wrap_down)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] cnt;
        logic       wu;
        logic       wd;
        int         at;
    } ev_t;

    ev_t  q[$];
    int   errors = 0;
    int   checks = 0;
    int   model  = 0;

    function automatic logic [6:0] seg_exp(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // queue the event that a press driven now must produce DB+3 cycles later (+extra)
    task automatic expect_press(input bit up, input int extra);
        ev_t e;
        e.wu = 1'b0;
        e.wd = 1'b0;
        if (up) begin
            if (model == MAXC) begin
                model = 0;
                e.wu  = 1'b1;
            end else begin
                model = model + 1;
            end
        end else begin
            if (model == 0) begin
                model = MAXC;
                e.wd  = 1'b1;
            end else begin
                model = model - 1;
            end
        end
        e.cnt = 4'(model);
        e.at  = cyc + DB + 3 + extra;
        q.push_back(e);
    endtask

    task automatic press(input bit up);
        expect_press(up, 0);
        if (up) btn_up = 1'b1;
        else    btn_down = 1'b1;
        tick(DB + 4);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(DB + 4);
    endtask

    // scoreboard monitor
    logic [3:0] prev      = 4'd0;
    logic       leds_pend = 1'b0;
    logic [6:0] leds_want = 7'd0;

    always @(negedge clk) begin
        ev_t e;
        if (reset) begin
            prev      = 4'd0;
            leds_pend = 1'b0;
        end else begin
            if (leds_pend) begin
                chk("leds_after_count", leds, leds_want);
                leds_pend = 1'b0;
            end
            if (count !== prev || wrap_up !== 1'b0 || wrap_down !== 1'b0) begin
                chk("event_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("ev_count", count, e.cnt);
                    chk("ev_wrap_up", wrap_up, e.wu);
                    chk("ev_wrap_down", wrap_down, e.wd);
                    chk("ev_cycle", cyc, e.at);
                    leds_pend = 1'b1;
                    leds_want = seg_exp(e.cnt);
                end
                prev = count;
            end
        end
    end

    initial begin
        reset    = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        #1;
        chk("reset_count", count, 4'd0);
        chk("reset_leds", leds, 7'b1111110);
        chk("reset_wrap_up", wrap_up, 1'b0);
        chk("reset_wrap_down", wrap_down, 1'b0);
        tick(3);
        reset = 1'b0;

        // latency: drive after posedge 10, count at 17, leds at 18
        while (cyc < 10) tick(1);
        btn_up = 1'b1;
        expect_press(1'b1, 0);
        while (cyc < 117) tick(1);
        chk("hold_no_repeat", count, 4'd1);
        btn_up = 1'b0;
        tick(DB + 4);

        // bounce then hold: exactly one increment
        for (int i = 0; i < 5; i++) begin
            btn_up = 1'b1;
            tick(2);
            btn_up = 1'b0;
            tick(2);
        end
        btn_up = 1'b1;
        expect_press(1'b1, 0);
        tick(DB + 14);
        btn_up = 1'b0;
        tick(DB + 4);
        chk("bounce_count", count, 4'd2);

        // 3-cycle glitches are one short of DB_LIMIT and must be ignored
        for (int i = 0; i < 3; i++) begin
            btn_up = 1'b1;
            tick(DB - 1);
            btn_up = 1'b0;
            tick(DB + 4);
        end
        chk("glitch_count", count, 4'd2);

        // wrap up through 9->0, then wrap down 0->9
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        model = 0;
        tick(2);
        for (int i = 0; i < 10; i++) press(1'b1);
        chk("wrap_up_final", count, 4'd0);
        press(1'b0);
        chk("wrap_down_final", count, 4'd9);

        // simultaneous presses at 4
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        model = 0;
        tick(2);
        for (int i = 0; i < 4; i++) press(1'b1);
        btn_up   = 1'b1;
        btn_down = 1'b1;
        tick(DB + 6);
        chk("simul_count", count, 4'd4);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(DB + 4);

        // offset by one cycle: 5 then 4
        btn_up = 1'b1;
        expect_press(1'b1, 0);
        tick(1);
        btn_down = 1'b1;
        expect_press(1'b0, 0);
        tick(DB + 6);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(DB + 4);
        chk("offset_count", count, 4'd4);

        // asynchronous reset from count 5
        press(1'b1);
        chk("pre_reset_count", count, 4'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_count", count, 4'd0);
        chk("async_reset_leds", leds, 7'b1111110);
        chk("async_reset_wraps", {wrap_up, wrap_down}, 2'b00);
        tick(2);
        reset = 1'b0;
        model = 0;
        tick(2);

        // reset 2 cycles into a down press, button held through release
        btn_down = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        expect_press(1'b0, 0);
        tick(DB + 20);
        btn_down = 1'b0;
        tick(DB + 4);
        chk("reset_mid_count", count, 4'd9);

        for (int i = 0; i < 50 && q.size() != 0; i++) tick(1);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
